// File: rtl/ws2812_pkg.sv
// Shared WS2812 line constants and receiver state encoding.
// Used by both the transmitter and the loopback receiver.
package ws2812_pkg;

  localparam int unsigned CLK_HZ       = 12_000_000;
  localparam int unsigned BIT_THRESH   = 7;
  localparam int unsigned MAX_HIGH     = 24;
  localparam int unsigned RESET_CYCLES = 600;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned PIX_W      = 24;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned PCNT_W     = 9;
  localparam int unsigned BIT_W      = 5;
  localparam int unsigned MAX_PIXELS = 256;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic [IDX_W-1:0] index;
  } pixel_t;

  // Saturating increment for the line-timing counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Receiver output bundle: decoded pixels, frame/error strobes and forwarded line.
interface ws2812_rx_if;
  import ws2812_pkg::*;

  logic              dout;
  logic [PIX_W-1:0]  pixel_data;
  logic [IDX_W-1:0]  pixel_index;
  logic              pixel_valid;
  logic              frame_done;
  logic [PCNT_W-1:0] pixel_count;
  logic              error;

  modport master (
    output dout, pixel_data, pixel_index, pixel_valid,
    output frame_done, pixel_count, error
  );

  modport slave (
    input dout, pixel_data, pixel_index, pixel_valid,
    input frame_done, pixel_count, error
  );

endinterface

// File: rtl/ws2812_rx_sync_edge.sv
// Two-flop synchronizer for the raw line plus rise/fall detection.
module ws2812_rx_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic din_s,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta  <= 1'b0;
      din_s <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= din;
      din_s <= meta;
      prev  <= din_s;
    end
  end

  assign rise_c = din_s & ~prev;
  assign fall_c = ~din_s & prev;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 line receiver: pulse-width decode into indexed 24-bit pixels,
// end-of-frame / error strobes, and forwarding of the stream past pixel 0.
module ws2812_rx
  import ws2812_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  ws2812_rx_if.master bus
);

  logic din_s;
  logic rise_c;
  logic fall_c;
  logic edge_c;
  logic bit_c;
  logic [PIX_W-1:0] word_c;

  logic [1:0]        state,    state_nxt;
  logic [CNT_W-1:0]  cnt,      cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt,  bit_cnt_nxt;
  logic [PIX_W-1:0]  shreg,    shreg_nxt;
  logic [PCNT_W-1:0] idx,      idx_nxt;
  logic              ovf,      ovf_nxt;
  logic              fwd,      fwd_nxt;
  pixel_t            pix_q,    pix_nxt;
  logic              valid_q,  valid_nxt;
  logic              fd_q,     fd_nxt;
  logic              err_q,    err_nxt;
  logic [PCNT_W-1:0] pcount_q, pcount_nxt;

  ws2812_rx_sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .din_s   (din_s),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  assign edge_c = rise_c | fall_c;
  // cnt holds completed high cycles minus one in the falling-edge cycle
  assign bit_c  = (cnt >= CNT_W'(BIT_THRESH - 1));
  assign word_c = {shreg[PIX_W-2:0], bit_c};

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = edge_c ? '0 : sat_inc(cnt);
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    idx_nxt     = idx;
    ovf_nxt     = ovf;
    fwd_nxt     = fwd;
    pix_nxt     = pix_q;
    valid_nxt   = 1'b0;
    fd_nxt      = 1'b0;
    err_nxt     = 1'b0;
    pcount_nxt  = pcount_q;

    case (state)
      ST_SYNC: begin
        if (!din_s && !edge_c && (cnt == CNT_W'(RESET_CYCLES - 1)))
          state_nxt = ST_LOW;
      end

      ST_LOW: begin
        if (rise_c) begin
          state_nxt = ST_HIGH;
        end else if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
          if (bit_cnt != '0) begin
            err_nxt = 1'b1;
          end else if (idx != '0) begin
            fd_nxt     = 1'b1;
            pcount_nxt = idx;
          end
          bit_cnt_nxt = '0;
          idx_nxt     = '0;
          ovf_nxt     = 1'b0;
          fwd_nxt     = 1'b0;
        end
      end

      ST_HIGH: begin
        // Over-long pulse wins over a coincident falling edge
        if (cnt >= CNT_W'(MAX_HIGH)) begin
          err_nxt     = 1'b1;
          state_nxt   = ST_SYNC;
          bit_cnt_nxt = '0;
          idx_nxt     = '0;
          ovf_nxt     = 1'b0;
          fwd_nxt     = 1'b0;
        end else if (fall_c) begin
          state_nxt = ST_LOW;
          shreg_nxt = word_c;
          if (bit_cnt == BIT_W'(PIX_W - 1)) begin
            bit_cnt_nxt = '0;
            if (idx == PCNT_W'(MAX_PIXELS)) begin
              if (!ovf) begin
                err_nxt = 1'b1;
                ovf_nxt = 1'b1;
              end
            end else begin
              pix_nxt.data  = word_c;
              pix_nxt.index = idx[IDX_W-1:0];
              valid_nxt     = 1'b1;
              idx_nxt       = idx + PCNT_W'(1);
              fwd_nxt       = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_SYNC;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      idx      <= '0;
      ovf      <= 1'b0;
      fwd      <= 1'b0;
      pix_q    <= '0;
      valid_q  <= 1'b0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
      pcount_q <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      idx      <= idx_nxt;
      ovf      <= ovf_nxt;
      fwd      <= fwd_nxt;
      pix_q    <= pix_nxt;
      valid_q  <= valid_nxt;
      fd_q     <= fd_nxt;
      err_q    <= err_nxt;
      pcount_q <= pcount_nxt;
    end
  end

  // Gated straight off the synchronizer flop so dout keeps a two-cycle lag
  assign bus.dout        = din_s & (fwd | (state == ST_SYNC));
  assign bus.pixel_data  = pix_q.data;
  assign bus.pixel_index = pix_q.index;
  assign bus.pixel_valid = valid_q;
  assign bus.frame_done  = fd_q;
  assign bus.pixel_count = pcount_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed/randomized bench for ws2812_rx against a frame-level pixel model.
module tb_ws2812_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b0;

  always #5 clk = ~clk;

  ws2812_rx_if bus ();

  ws2812_rx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] got_px[$];
  logic [8:0]  got_fd[$];
  int          err_cnt = 0;
  int          err_base = 0;

  logic [23:0] exp_q[$];
  int          exp_err = 0;
  bit          exp_ovf = 1'b0;

  logic d1 = 1'b0;
  logic d2 = 1'b0;
  int   dout_mode = 0;
  int   dout_bad = 0;

  logic [23:0] pat [4] = '{24'h100000, 24'h001000, 24'h000010, 24'h101010};

  // Line delayed by two clocks: what a forwarding dout must show
  always @(posedge clk) begin
    d1 <= din;
    d2 <= d1;
  end

  always @(negedge clk) begin
    if (bus.pixel_valid === 1'b1) got_px.push_back({bus.pixel_index, bus.pixel_data});
    if (bus.frame_done === 1'b1) got_fd.push_back(bus.pixel_count);
    if (bus.error === 1'b1) err_cnt++;
    if (dout_mode == 1 && bus.dout !== 1'b0) dout_bad++;
    if (dout_mode == 2 && bus.dout !== d2) dout_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    cyc(hi);
    din = 1'b0;
    cyc(lo);
  endtask

  task automatic send_bit(input bit b, input bit fast);
    if (fast) pulse(b ? 7 : 1, 2);
    else pulse(b ? int'($urandom_range(24, 7)) : int'($urandom_range(6, 2)),
               int'($urandom_range(14, 5)));
  endtask

  task automatic send_word(input logic [23:0] w, input bit fast);
    for (int i = 23; i >= 0; i--) send_bit(w[i], fast);
  endtask

  // Frame model: first 256 pixels are reported, the 257th raises one error
  function automatic void model_pixel(input logic [23:0] w);
    if (exp_q.size() < 256) exp_q.push_back(w);
    else if (!exp_ovf) begin
      exp_ovf = 1'b1;
      exp_err++;
    end
  endfunction

  task automatic send_pixel(input logic [23:0] w, input bit fast);
    send_word(w, fast);
    model_pixel(w);
  endtask

  task automatic check_frame(input string tag, input int exp_fd_n);
    int n;
    n = exp_q.size();
    chk({tag, "/npix"}, 64'(got_px.size()), 64'(n));
    for (int i = 0; i < n && i < got_px.size(); i++)
      chk($sformatf("%s/px%0d", tag, i), 64'(got_px[i]), 64'({8'(i), exp_q[i]}));
    chk({tag, "/nframe"}, 64'(got_fd.size()), 64'(exp_fd_n));
    if (exp_fd_n == 1 && got_fd.size() == 1)
      chk({tag, "/count"}, 64'(got_fd[0]), 64'(n));
    chk({tag, "/errors"}, 64'(err_cnt - err_base), 64'(exp_err));
    got_px.delete();
    got_fd.delete();
    exp_q.delete();
    exp_err  = 0;
    exp_ovf  = 1'b0;
    err_base = err_cnt;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "/valid"}, 64'(bus.pixel_valid), 64'(0));
    chk({tag, "/frame_done"}, 64'(bus.frame_done), 64'(0));
    chk({tag, "/error"}, 64'(bus.error), 64'(0));
    chk({tag, "/data"}, 64'(bus.pixel_data), 64'(0));
    chk({tag, "/index"}, 64'(bus.pixel_index), 64'(0));
    chk({tag, "/count"}, 64'(bus.pixel_count), 64'(0));
    chk({tag, "/dout"}, 64'(bus.dout), 64'(0));
  endtask

  initial begin
    logic [23:0] w;
    int n;

    cyc(3);
    check_idle("reset");
    reset_n = 1'b1;

    // Single nominal-timing pixel after an initial long low
    cyc(700);
    w = 24'h100000;
    for (int i = 23; i >= 0; i--) pulse(w[i] ? 10 : 5, w[i] ? 5 : 10);
    model_pixel(w);
    cyc(700);
    check_frame("single", 1);

    // Loopback pattern, dout held low until pixel 0 completes
    dout_mode = 1;
    for (int p = 0; p < 8; p++) begin
      send_pixel(pat[p % 4], 1'b0);
      if (p == 0) dout_mode = 2;
    end
    dout_mode = 0;
    cyc(700);
    chk("dout_fwd", 64'(dout_bad), 64'(0));
    check_frame("loop8", 1);

    // Random-length frame of random pixels
    n = int'($urandom_range(10, 3));
    for (int p = 0; p < n; p++) send_pixel(24'($urandom), 1'b0);
    cyc(700);
    check_frame("random", 1);

    // Threshold corners: 6 -> 0, 7 and 24 -> 1
    w = {2'b10, 22'($urandom)};
    for (int i = 23; i >= 0; i--) pulse(w[i] ? ((i % 2 == 1) ? 7 : 24) : 6, 8);
    model_pixel(w);
    cyc(700);
    check_frame("thresh", 1);

    // 25-cycle high: error, resync, following pixel ignored until long low
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    pulse(25, 10);
    exp_err = 1;
    send_word(24'($urandom), 1'b0);
    cyc(700);
    send_pixel(24'($urandom), 1'b0);
    cyc(700);
    check_frame("longhigh", 1);

    // Partial pixel at end of frame
    for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1'b0);
    cyc(700);
    exp_err = 1;
    check_frame("partial", 0);
    send_pixel(24'($urandom), 1'b0);
    send_pixel(24'($urandom), 1'b0);
    cyc(700);
    check_frame("after_partial", 1);

    // 257 pixels: index saturates, one error, count 256
    for (int p = 0; p < 257; p++) send_pixel({16'h0, 8'(p)}, 1'b1);
    cyc(700);
    check_frame("overflow", 1);

    // Asynchronous reset after bit 10 of a pixel
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
    #3 reset_n = 1'b0;
    #1 check_idle("async_reset");
    cyc(3);
    reset_n = 1'b1;
    send_word(24'($urandom), 1'b0);
    cyc(700);
    send_pixel(24'($urandom), 1'b0);
    cyc(700);
    check_frame("post_reset", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

WS2812 serial-line receiver: decodes the single-wire NRZ pulse-width stream produced by the team's `ws2812` transmitter (or any WS2812 controller) back into 24-bit pixel words with an index, and reports frame boundaries and line errors. Used as a loopback checker on a PMOD pin, and as a cascadable "virtual LED" that captures its own pixel and forwards the remainder of the stream on `dout`. Runs on the 12 MHz `clk_in` domain; all line timing is expressed in clock cycles.

## Interface
- `BIT_THRESH`, 7: high-pulse length in cycles at or above which a bit decodes as 1; below it decodes as 0.
- `MAX_HIGH`, 24: a high pulse longer than this many cycles is a line error.
- `RESET_CYCLES`, 600: continuous low time in cycles that marks the end of a frame (50 us at 12 MHz).
- `clk`  input  1  system clock (12 MHz `clk_in`).
- `reset_n`  input  1  asynchronous, active-low reset.
- `din`  input  1  raw WS2812 line, asynchronous to `clk`.
- `dout`  output  1  forwarded line: low while the first pixel of a frame is captured, then follows the synchronized `din`.
- `pixel_data`  output  24  last decoded pixel; the first received bit lands in bit 23, with no colour reordering.
- `pixel_index`  output  8  index of `pixel_data` within the current frame, starting at 0.
- `pixel_valid`  output  1  one-cycle strobe; `pixel_data` and `pixel_index` are valid and stable until the next strobe.
- `frame_done`  output  1  one-cycle strobe at end-of-frame when at least one pixel was received.
- `pixel_count`  output  9  number of pixels in the frame just ended; updated with `frame_done`.
- `error`  output  1  one-cycle strobe on any line error.

## Operation
- Input path: `din` passes through a 2-FF synchronizer, then a `prev` register is used for edge detection. All decoding uses the synchronized signal.
- The 16-bit cycle counter saturates at all-ones and is cleared on every synchronized edge.
- States:
  - SYNC (after reset or error): waits until the line has been continuously low for `RESET_CYCLES`, then goes to LOW. Edges in SYNC restart the wait, and no pixels are produced.
  - LOW: counts low time.
    - Rising edge: go to HIGH.
    - Count reaches `RESET_CYCLES`: end-of-frame. If `bit_cnt` is not 0, strobe `error` (partial pixel). Otherwise, if at least one pixel was received, strobe `frame_done`. Then clear `bit_cnt`, the index and the first-pixel flag, and stay in LOW.
  - HIGH: counts high time.
    - Count exceeds `MAX_HIGH`: strobe `error`, discard the partial pixel, go to SYNC.
    - Falling edge: shift in (count >= `BIT_THRESH`) and go to LOW.
- Pixel assembly:
  - A 24-bit shift register fills MSB first. `bit_cnt` runs 0..23.
  - On the 24th bit, the word is loaded into `pixel_data`, `pixel_valid` is strobed, and `pixel_index` takes the current index. The index then increments.
  - The index saturates: pixel 256 and beyond strobe `error` once and are not reported. `pixel_count` saturates at 256.
- Forwarding: `dout` is held 0 from end-of-frame until the 24th bit of pixel 0 completes. After that it equals the synchronized `din` for the rest of the frame. While in SYNC, `dout` equals the synchronized `din`.

## Timing
- Reset values: all outputs 0, state SYNC, counters 0.
- Latency: strobes assert on the 3rd `clk` rising edge after the corresponding raw `din` transition (2 synchronizer edges plus 1 edge for the registered output), with ±1 cycle sampling uncertainty. `dout` lags `din` by 2 cycles.
- End-of-frame fires exactly `RESET_CYCLES` synchronized-low cycles after the last falling edge.
- Boundary cases:
  - A falling edge in the same cycle the high count would exceed `MAX_HIGH`: the error takes priority.
  - `reset_n` asserted mid-frame: everything clears immediately and outputs go to 0.
- Decoding margin at 12 MHz: nominal T0H of 0.4 us is about 5 cycles; nominal T1H of 0.8 us is about 10 cycles.

## Structure
- A shared `ws2812_pkg` holds the state encoding and the default timing constants (`BIT_THRESH`, `MAX_HIGH`, `RESET_CYCLES`, `CLK_HZ`). The existing transmitter uses the same package.
- One natural sub-module: `sync_edge` (2-FF synchronizer plus rise/fall detect). The FSM, counters and shift register stay in `ws2812_rx`.

## Test plan
- Sync and idle: hold `din` low for 700 cycles after reset, then send pixel 24'h10_00_00 (0 = 5 cycles high / 10 low, 1 = 10 high / 5 low), then 700 cycles low. Expect one `pixel_valid` with data 24'h100000, index 0; one `frame_done` with `pixel_count` = 1; `error` never strobes.
- Back-to-back frame of 8 pixels cycling 24'h100000, 24'h001000, 24'h000010, 24'h101010 (the loopback pattern from the `ws2812` transmitter). Expect indices 0..7 with matching data, `pixel_count` = 8, and `dout` low until pixel 0 completes, then mirroring `din`.
- Threshold edges: high pulses of 6 and 7 cycles decode as 0 and 1 respectively. A 25-cycle high pulse strobes `error` and the block re-enters SYNC; no pixel is reported until 600 low cycles have elapsed.
- Partial pixel: send 12 bits, then 700 cycles low. Expect `error`, no `frame_done`, and the next frame decoding from index 0.
- Overflow: send 257 pixels. Expect indices 0..255, a single `error` on pixel 257, and `pixel_count` = 256.
- Reset mid-pixel: assert `reset_n` low after bit 10. All outputs go to 0 asynchronously; after release, pixels are ignored until a 600-cycle low is seen.
